// File: rtl/lpc_pkg.sv
// lpc_pkg: shared LPC constants for the host I/O initiator.
//   - START and cycle-type nibbles driven by the host
//   - SYNC codes returned by the target
//   - host FSM state encoding and abort length
//   - addr_nibble(): selects the address nibble for each ADDR cycle (MSB first)
package lpc_pkg;

    localparam logic [3:0] START_NIB  = 4'b0000;
    localparam logic [3:0] CYC_IO_RD  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SWAIT = 4'b0101;
    localparam logic [3:0] SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;

    localparam int unsigned ABORT_CYCLES = 4;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StCyctype,
        StAddr,
        StWdata,
        StHtar,
        StSync,
        StRdata,
        StPtar,
        StAbort
    } lpc_state_e;

    // idx 0 returns addr[15:12], idx 3 returns addr[3:0]
    function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
        logic [3:0] nib;
        unique case (idx)
            2'd0:    nib = addr[15:12];
            2'd1:    nib = addr[11:8];
            2'd2:    nib = addr[7:4];
            default: nib = addr[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/lpc_host_io_if.sv
// lpc_host_io_if: request/response handshake plus LPC bus pins of the host.
//   master: requester and bus target side (drives req_*, lpc_ad_in)
//   slave : lpc_host_io (drives req_ready, rsp_*, lpc_frame, lpc_ad_out, lpc_ad_oe)
interface lpc_host_io_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;

    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;

    logic        lpc_frame;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, lpc_ad_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, lpc_frame, lpc_ad_out, lpc_ad_oe
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, lpc_ad_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, lpc_frame, lpc_ad_out, lpc_ad_oe
    );
endinterface

// File: rtl/lpc_host_sync_timer.sv
// lpc_host_sync_timer: counts SYNC cycles that end without ready/error.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the count (asserted in the cycle before SYNC is entered)
//   active    : host is in SYNC this cycle
//   sync_code : target nibble sampled this cycle
//   expired   : this SYNC cycle is the SYNC_TIMEOUT-th without progress
// A long-wait code disables expiry for the rest of the current cycle.
module lpc_host_sync_timer
    import lpc_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       active,
    input  logic [3:0] sync_code,
    output logic       expired
);
    localparam int unsigned CW = $clog2(SYNC_TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic          stop_q;
    logic          lwait;

    assign lwait   = active && (sync_code == SYNC_LWAIT);
    assign expired = active && !stop_q && !lwait && (count_q == CW'(SYNC_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            stop_q  <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
            stop_q  <= 1'b0;
        end else if (active) begin
            if (lwait) begin
                stop_q <= 1'b1;
            end else if (!stop_q && !expired) begin
                count_q <= count_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/lpc_host_io.sv
// lpc_host_io: LPC host (initiator) for I/O read and write cycles.
//   lpc_clock : LPC clock, all logic on the rising edge
//   lpc_reset : asynchronous active-high reset; releases the bus at once
//   bus       : lpc_host_io_if.slave (request, response and LPC pins)
// Optional macro LPC_HOST_TIMEOUT_EN: aborts a cycle whose SYNC phase lasts
// SYNC_TIMEOUT cycles without ready/error (long wait disables the timeout).
// All outputs are registered and change together with the state.
module lpc_host_io
    import lpc_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT = 32
) (
    input logic          lpc_clock,
    input logic          lpc_reset,
    lpc_host_io_if.slave bus
);
    lpc_state_e  state_q;
    logic [1:0]  cnt_q;
    logic        write_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        err_q;

    logic        frame_q;
    logic [3:0]  ad_q;
    logic        oe_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_error_q;

`ifdef LPC_HOST_TIMEOUT_EN
    logic sync_expired;

    lpc_host_sync_timer #(
        .SYNC_TIMEOUT(SYNC_TIMEOUT)
    ) u_sync_timer (
        .clk      (lpc_clock),
        .rst      (lpc_reset),
        .clear    ((state_q == StHtar) && (cnt_q == 2'd1)),
        .active   (state_q == StSync),
        .sync_code(bus.lpc_ad_in),
        .expired  (sync_expired)
    );
`endif

    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            write_q     <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            frame_q     <= 1'b1;
            ad_q        <= 4'hf;
            oe_q        <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    frame_q <= 1'b1;
                    oe_q    <= 1'b0;
                    ad_q    <= 4'hf;
                    if (ready_q && bus.req_valid) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        rdata_q <= 8'h00;
                        err_q   <= 1'b0;
                        ready_q <= 1'b0;
                        frame_q <= 1'b0;
                        ad_q    <= START_NIB;
                        oe_q    <= 1'b1;
                        state_q <= StStart;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StStart: begin
                    frame_q <= 1'b1;
                    ad_q    <= write_q ? CYC_IO_WR : CYC_IO_RD;
                    state_q <= StCyctype;
                end
                StCyctype: begin
                    cnt_q   <= 2'd0;
                    ad_q    <= addr_nibble(addr_q, 2'd0);
                    state_q <= StAddr;
                end
                // cnt_q is the index of the nibble currently on the bus
                StAddr: begin
                    if (cnt_q == 2'd3) begin
                        cnt_q <= 2'd0;
                        if (write_q) begin
                            ad_q    <= wdata_q[3:0];
                            state_q <= StWdata;
                        end else begin
                            ad_q    <= 4'hf;
                            state_q <= StHtar;
                        end
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                        ad_q  <= addr_nibble(addr_q, cnt_q + 2'd1);
                    end
                end
                StWdata: begin
                    if (cnt_q == 2'd0) begin
                        cnt_q <= 2'd1;
                        ad_q  <= wdata_q[7:4];
                    end else begin
                        cnt_q   <= 2'd0;
                        ad_q    <= 4'hf;
                        state_q <= StHtar;
                    end
                end
                StHtar: begin
                    if (cnt_q == 2'd0) begin
                        cnt_q <= 2'd1;
                        oe_q  <= 1'b0;
                    end else begin
                        cnt_q   <= 2'd0;
                        state_q <= StSync;
                    end
                end
                StSync: begin
                    cnt_q <= 2'd0;
                    if (bus.lpc_ad_in == SYNC_READY) begin
                        state_q <= write_q ? StPtar : StRdata;
                    end else if (bus.lpc_ad_in == SYNC_ERROR) begin
                        err_q   <= 1'b1;
                        state_q <= StPtar;
                    end
`ifdef LPC_HOST_TIMEOUT_EN
                    else if (sync_expired) begin
                        frame_q <= 1'b0;
                        ad_q    <= 4'hf;
                        oe_q    <= 1'b1;
                        state_q <= StAbort;
                    end
`endif
                end
                StRdata: begin
                    if (cnt_q == 2'd0) begin
                        rdata_q[3:0] <= bus.lpc_ad_in;
                        cnt_q        <= 2'd1;
                    end else begin
                        rdata_q[7:4] <= bus.lpc_ad_in;
                        cnt_q        <= 2'd0;
                        state_q      <= StPtar;
                    end
                end
                StPtar: begin
                    if (cnt_q == 2'd0) begin
                        cnt_q       <= 2'd1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= write_q ? 8'h00 : rdata_q;
                        rsp_error_q <= err_q;
                    end else begin
                        cnt_q   <= 2'd0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
`ifdef LPC_HOST_TIMEOUT_EN
                // Abort then reuse PTAR for the release cycle and the error response
                StAbort: begin
                    if (cnt_q == 2'(ABORT_CYCLES - 1)) begin
                        cnt_q   <= 2'd0;
                        frame_q <= 1'b1;
                        oe_q    <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= StPtar;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
`endif
                default: begin
                    cnt_q   <= 2'd0;
                    frame_q <= 1'b1;
                    oe_q    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_error  = rsp_error_q;
    assign bus.lpc_frame  = frame_q;
    assign bus.lpc_ad_out = ad_q;
    assign bus.lpc_ad_oe  = oe_q;
endmodule
